// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and op-class helper.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 6-9).
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for ops that occupy the unit for multiple cycles (and so stall MFHI/MFLO).
  function automatic logic is_muldiv(input logic [3:0] op);
    logic res;
    res = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_busy_cnt.sv
// Loadable 5-bit down-counter that tracks the remaining busy cycles of an MDU op.
// done flags the final busy cycle (count==1).
module mdu_busy_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic       done
);

  logic [4:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 5'd0) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 5'd1);

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: computes mul/div results at accept, holds them in shadow regs for a fixed
// latency, then commits to HI/LO. Define MDU_MADD_EN to enable the MADD/MSUB family.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;

  logic        cnt_load;
  logic [4:0]  cnt_val;
  logic        cnt_done;
  logic        accept;

  logic [63:0] prod_s, prod_u;
  logic        div_zero;
  logic [31:0] abs_a, abs_b, sdiv_b, udiv_b;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
`endif

  mdu_busy_cnt u_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  always_comb begin
    prod_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero = (rt_val == 32'd0);
    abs_a    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    abs_b    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    sdiv_b   = div_zero ? 32'd1 : abs_b;
    udiv_b   = div_zero ? 32'd1 : rt_val;
    q_mag    = abs_a / sdiv_b;
    r_mag    = abs_a % sdiv_b;
    q_s      = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s      = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    q_u      = rs_val / udiv_b;
    r_u      = rs_val % udiv_b;
`ifdef MDU_MADD_EN
    acc      = {hi_q, lo_q};
`endif
  end

  assign accept = start & ~flush & (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_nx_d  = hi_nx_q;
    lo_nx_d  = lo_nx_q;
    cnt_load = 1'b0;
    cnt_val  = 5'd0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            MDU_MULT: begin
              {hi_nx_d, lo_nx_d} = prod_s;
              cnt_load = 1'b1;
              cnt_val  = MULT_LOAD;
              state_d  = ST_RUN;
            end
            MDU_MULTU: begin
              {hi_nx_d, lo_nx_d} = prod_u;
              cnt_load = 1'b1;
              cnt_val  = MULT_LOAD;
              state_d  = ST_RUN;
            end
            // Divide by zero shadows the current HI/LO so the commit is a no-op.
            MDU_DIV: begin
              hi_nx_d  = div_zero ? hi_q : r_s;
              lo_nx_d  = div_zero ? lo_q : q_s;
              cnt_load = 1'b1;
              cnt_val  = DIV_LOAD;
              state_d  = ST_RUN;
            end
            MDU_DIVU: begin
              hi_nx_d  = div_zero ? hi_q : r_u;
              lo_nx_d  = div_zero ? lo_q : q_u;
              cnt_load = 1'b1;
              cnt_val  = DIV_LOAD;
              state_d  = ST_RUN;
            end
            MDU_MTHI: hi_d = rs_val;
            MDU_MTLO: lo_d = rs_val;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
              case (op)
                MDU_MADD:  {hi_nx_d, lo_nx_d} = acc + prod_s;
                MDU_MADDU: {hi_nx_d, lo_nx_d} = acc + prod_u;
                MDU_MSUB:  {hi_nx_d, lo_nx_d} = acc - prod_s;
                default:   {hi_nx_d, lo_nx_d} = acc - prod_u;
              endcase
              cnt_load = 1'b1;
              cnt_val  = MULT_LOAD;
              state_d  = ST_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_done) begin
          hi_d    = hi_nx_q;
          lo_d    = lo_nx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_nx_q <= 32'd0;
      lo_nx_q <= 32'd0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_nx_q <= hi_nx_d;
      lo_nx_q <= lo_nx_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign md_stall = busy | (start & ~flush & is_muldiv(op));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, hand-written timing sequences and
// randomized ops against a plain-arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] rs_i = 32'd0;
  logic [31:0] rt_i = 32'd0;
  logic        flush = 1'b0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .rs_val(rs_i), .rt_val(rt_i),
    .flush(flush), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules, using 64-bit integers.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] h, input logic [31:0] l,
                                 output logic [31:0] nh, output logic [31:0] nl, output int lat);
    longint sa, sb, q, r;
    logic [63:0] acc, ps, pu;
    sa  = longint'($signed(rs));
    sb  = longint'($signed(rt));
    ps  = sa * sb;
    pu  = {32'd0, rs} * {32'd0, rt};
    acc = {h, l};
    nh  = h;
    nl  = l;
    lat = 0;
    case (op)
      4'd0: begin {nh, nl} = ps; lat = MULT_CYCLES; end
      4'd1: begin {nh, nl} = pu; lat = MULT_CYCLES; end
      4'd2: begin
        lat = DIV_CYCLES;
        if (rt != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          nl = q[31:0];
          nh = r[31:0];
        end
      end
      4'd3: begin
        lat = DIV_CYCLES;
        if (rt != 32'd0) begin
          nl = rs / rt;
          nh = rs % rt;
        end
      end
      4'd4: nh = rs;
      4'd5: nl = rs;
`ifdef MDU_MADD_EN
      4'd6: begin {nh, nl} = acc + ps; lat = MULT_CYCLES; end
      4'd7: begin {nh, nl} = acc + pu; lat = MULT_CYCLES; end
      4'd8: begin {nh, nl} = acc - ps; lat = MULT_CYCLES; end
      4'd9: begin {nh, nl} = acc - pu; lat = MULT_CYCLES; end
`endif
      default: ;
    endcase
  endfunction

  task automatic write_hl(input logic [31:0] h, input logic [31:0] l);
    start = 1'b1; op_i = 4'd4; rs_i = h;
    tick();
    op_i = 4'd5; rs_i = l;
    tick();
    start = 1'b0;
  endtask

  // Issue one op, count busy cycles, then compare latency and committed HI/LO.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input int exp_lat,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1; op_i = op; rs_i = rs; rt_i = rt; flush = 1'b0;
    #1;
    check({name, ".md_stall"}, 64'(md_stall), 64'(exp_lat > 0));
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    check({name, ".latency"}, 64'(n), 64'(exp_lat));
    check({name, ".hi"}, 64'(hi), 64'(exp_hi));
    check({name, ".lo"}, 64'(lo), 64'(exp_lo));
    $display("%s op=%0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d", name, op, rs, rt, hi, lo, n);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] pre_hi, pre_lo, rs, rt;
    int          lat;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n, seen;
    logic [31:0] mhi, mlo, eh, el;
    int lat;

    vecs[0]  = '{"mult_neg",   4'd0, 32'h0, 32'h0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_max",  4'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"mult_min",   4'd0, 32'h0, 32'h0, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000};
    vecs[3]  = '{"div_neg",    4'd2, 32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"div_negdiv", 4'd2, 32'h0, 32'h0, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[5]  = '{"div_ovf",    4'd2, 32'h1, 32'h1, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[6]  = '{"divu_zero",  4'd3, 32'hAAAA0000, 32'h00005555, 32'd7, 32'd0, 10, 32'hAAAA0000, 32'h00005555};
    vecs[7]  = '{"divu_big",   4'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd16, 10, 32'h0000000F, 32'h0FFFFFFF};
    vecs[8]  = '{"mthi",       4'd4, 32'h0, 32'h9, 32'h12345678, 32'd0, 0, 32'h12345678, 32'h00000009};
    vecs[9]  = '{"noop_f",     4'd15, 32'h3, 32'h4, 32'h11, 32'h22, 0, 32'h00000003, 32'h00000004};
`ifdef MDU_MADD_EN
    vecs[10] = '{"madd",       4'd6, 32'h0, 32'h1, 32'd2, 32'd3, 5, 32'h00000000, 32'h00000007};
`else
    vecs[10] = '{"madd_off",   4'd6, 32'h0, 32'h1, 32'd2, 32'd3, 0, 32'h00000000, 32'h00000001};
`endif

    repeat (3) tick();
    reset = 1'b0;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.md_stall", 64'(md_stall), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);

    for (int i = 0; i < 11; i++) begin
      write_hl(vecs[i].pre_hi, vecs[i].pre_lo);
      do_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].lat,
            vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Exact MULT timing: old values for 5 busy cycles, new values in the 6th cycle.
    write_hl(32'd0, 32'd0);
    start = 1'b1; op_i = 4'd0; rs_i = 32'hFFFFFFFE; rt_i = 32'd3;
    #1;
    check("tim.stall_start", 64'(md_stall), 64'd1);
    check("tim.busy_start", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check("tim.busy", 64'(busy), 64'd1);
      check("tim.stall", 64'(md_stall), 64'd1);
      check("tim.lo_old", 64'(lo), 64'd0);
      tick();
    end
    check("tim.busy_end", 64'(busy), 64'd0);
    check("tim.hi", 64'(hi), 64'hFFFFFFFF);
    check("tim.lo", 64'(lo), 64'hFFFFFFFA);
    $display("timing mult hi=%h lo=%h", hi, lo);

    // start together with flush: nothing accepted.
    write_hl(32'h55, 32'h66);
    start = 1'b1; flush = 1'b1; op_i = 4'd0; rs_i = 32'd9; rt_i = 32'd9;
    #1;
    check("flush_start.stall", 64'(md_stall), 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (busy) seen++;
      tick();
    end
    check("flush_start.busy", 64'(seen), 64'd0);
    check("flush_start.hi", 64'(hi), 64'h55);
    check("flush_start.lo", 64'(lo), 64'h66);
    $display("flush+start hi=%h lo=%h", hi, lo);

    // flush in busy cycle 3 does not disturb the in-flight MULT.
    start = 1'b1; op_i = 4'd0; rs_i = 32'd4; rt_i = 32'd5;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      flush = (n == 3);
      tick();
    end
    flush = 1'b0;
    check("flush_run.latency", 64'(n), 64'd5);
    check("flush_run.lo", 64'(lo), 64'd20);
    check("flush_run.hi", 64'(hi), 64'd0);
    $display("flush in run lo=%h cycles=%0d", lo, n);

    // MTLO presented while busy is ignored.
    start = 1'b1; op_i = 4'd0; rs_i = 32'd2; rt_i = 32'd2;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      start = (n == 2); op_i = 4'd5; rs_i = 32'hDEAD;
      tick();
    end
    start = 1'b0;
    check("mtlo_busy.latency", 64'(n), 64'd5);
    check("mtlo_busy.lo", 64'(lo), 64'd4);
    $display("mtlo while busy lo=%h", lo);

    // Reset in busy cycle 2 of a DIV cancels the commit.
    write_hl(32'h11, 32'h22);
    start = 1'b1; op_i = 4'd2; rs_i = 32'd100; rt_i = 32'd7;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.hi", 64'(hi), 64'd0);
    check("rst_mid.lo", 64'(lo), 64'd0);
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      if (busy) seen++;
      tick();
    end
    check("rst_mid.later_busy", 64'(seen), 64'd0);
    check("rst_mid.later_hi", 64'(hi), 64'd0);
    check("rst_mid.later_lo", 64'(lo), 64'd0);
    $display("reset mid-div hi=%h lo=%h", hi, lo);

    // Random ops against the reference model.
    mhi = $urandom;
    mlo = $urandom;
    write_hl(mhi, mlo);
    for (int i = 0; i < 60; i++) begin
      logic [3:0] rop;
      logic [31:0] rs, rt;
      int k;
      k   = $urandom_range(0, 11);
      rop = (k <= 9) ? 4'(k) : 4'd12;
      rs  = $urandom;
      rt  = $urandom;
      case ($urandom_range(0, 5))
        0: rt = 32'd0;
        1: rt = 32'($urandom_range(1, 9));
        2: begin rs = 32'h80000000; rt = 32'hFFFFFFFF; end
        3: rs = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      ref_op(rop, rs, rt, mhi, mlo, eh, el, lat);
      do_op("rand", rop, rs, rt, lat, eh, el);
      mhi = eh;
      mlo = el;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
